// File: rtl/fxy_sweep_if.sv
// Handshake and result bundle between the fxy sweep sequencer and its user.
// The slave modport is the sequencer side; the master modport is the requester and function-unit side.
interface fxy_sweep_if #(
   parameter int unsigned NVARS = 3
);
   localparam int unsigned NPAT = 2 ** NVARS;

   logic             start;
   logic             abort;
   logic             s_in;
   logic [NVARS-1:0] vars;
   logic             busy;
   logic             done;
   logic [NPAT-1:0]  tt;
   logic [NVARS:0]   ones_cnt;
   logic             mismatch;

   modport master (
      output start, abort, s_in,
      input  vars, busy, done, tt, ones_cnt, mismatch
   );

   modport slave (
      input  start, abort, s_in,
      output vars, busy, done, tt, ones_cnt, mismatch
   );
endinterface

// File: rtl/fxy_sweep_ctrl.sv
// Truth-table sweep sequencer for the fxy boolean-function unit.
// Optional feature macro: FXY_SWEEP_CHECK_EN adds the expected-table comparator.
module fxy_sweep_ctrl #(
   parameter int unsigned               NVARS     = 3,
   parameter int unsigned               SETTLE    = 1,
   parameter logic [(2**NVARS)-1:0]     EXPECT_TT = (2**NVARS)'(8'h02)
) (
   input  logic        clk,
   input  logic        reset,
   fxy_sweep_if.slave  bus
);
   localparam int unsigned NPAT  = 2 ** NVARS;
   localparam int unsigned OW    = NVARS + 1;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [NVARS-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NVARS-1:0]   vars_q, vars_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic [NPAT-1:0]    tt_q, tt_nxt;
   logic [OW-1:0]      ones_q, ones_nxt;
`ifdef FXY_SWEEP_CHECK_EN
   logic               mism_q, mism_nxt;
`endif

   // State register and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         idx    <= '0;
         cnt    <= '0;
         vars_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         tt_q   <= '0;
         ones_q <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         vars_q <= vars_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         tt_q   <= tt_nxt;
         ones_q <= ones_nxt;
      end
   end

`ifdef FXY_SWEEP_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mism_q <= 1'b0;
      else       mism_q <= mism_nxt;
   end
`endif

   // Next state plus next values of every registered output
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      tt_nxt    = tt_q;
      ones_nxt  = ones_q;
`ifdef FXY_SWEEP_CHECK_EN
      mism_nxt  = mism_q;
`endif

      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               idx_nxt   = '0;
               cnt_nxt   = '0;
               tt_nxt    = '0;
               ones_nxt  = '0;
`ifdef FXY_SWEEP_CHECK_EN
               mism_nxt  = 1'b0;
`endif
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (bus.abort)                      state_nxt = S_IDLE;
            else if (cnt == CNT_W'(SETTLE - 1)) state_nxt = S_SAMPLE;
         end
         S_SAMPLE: begin
            // abort discards this cycle's sample entirely
            if (bus.abort) begin
               state_nxt = S_IDLE;
            end else begin
               tt_nxt[idx] = bus.s_in;
               ones_nxt    = ones_q + OW'(bus.s_in);
               if (&idx) begin
                  state_nxt = S_DONE;
`ifdef FXY_SWEEP_CHECK_EN
                  mism_nxt  = (tt_nxt != EXPECT_TT);
`endif
               end else begin
                  idx_nxt   = idx + NVARS'(1);
                  cnt_nxt   = '0;
                  state_nxt = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
      vars_nxt = busy_nxt ? idx_nxt : '0;
      done_nxt = (state_nxt == S_DONE);
   end

   assign bus.vars     = vars_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.tt       = tt_q;
   assign bus.ones_cnt = ones_q;

`ifdef FXY_SWEEP_CHECK_EN
   assign bus.mismatch = mism_q;
`else
   assign bus.mismatch = 1'b0;
   wire unused_expect = ^EXPECT_TT;
`endif

endmodule

// File: tb/tb_fxy_sweep_ctrl.sv
// Self-checking bench for fxy_sweep_ctrl: a SETTLE=1 and a SETTLE=3 instance driven
// with random truth tables and checked against a table-driven reference.
module tb_fxy_sweep_ctrl;
   logic clk;
   logic reset;
   logic start;
   logic abort;
   int   sel;
   logic [7:0] fn;

   int errors = 0;
   int checks = 0;

   fxy_sweep_if #(.NVARS(3)) if_a ();
   fxy_sweep_if #(.NVARS(3)) if_b ();

   fxy_sweep_ctrl #(.NVARS(3), .SETTLE(1)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   fxy_sweep_ctrl #(.NVARS(3), .SETTLE(3)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

   // The function unit is modelled as a lookup into the current truth table fn
   assign if_a.start = start && (sel == 0);
   assign if_a.abort = abort && (sel == 0);
   assign if_a.s_in  = fn[if_a.vars];
   assign if_b.start = start && (sel == 1);
   assign if_b.abort = abort && (sel == 1);
   assign if_b.s_in  = fn[if_b.vars];

   logic [2:0] o_vars;
   logic       o_busy, o_done, o_mm;
   logic [7:0] o_tt;
   logic [3:0] o_ones;

   always_comb begin
      if (sel == 0) begin
         o_vars = if_a.vars; o_busy = if_a.busy; o_done = if_a.done;
         o_tt   = if_a.tt;   o_ones = if_a.ones_cnt; o_mm = if_a.mismatch;
      end else begin
         o_vars = if_b.vars; o_busy = if_b.busy; o_done = if_b.done;
         o_tt   = if_b.tt;   o_ones = if_b.ones_cnt; o_mm = if_b.mismatch;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_mismatch(input logic [7:0] table_v);
`ifdef FXY_SWEEP_CHECK_EN
      return (table_v != 8'h02);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_vars"}, 32'(o_vars), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_tt"},   32'(o_tt),   32'd0);
      chk({tag, "_ones"}, 32'(o_ones), 32'd0);
      chk({tag, "_mm"},   32'(o_mm),   32'd0);
   endtask

   // Full sweep: pattern p is on vars for edges p*(S+1)..p*(S+1)+S, done at edge 8*(S+1)
   task automatic full_sweep(input int which, input int settle, input logic [7:0] f);
      int last;
      sel   = which;
      fn    = f;
      last  = 8 * (settle + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sw_e0_vars", 32'(o_vars), 32'd0);
      chk("sw_e0_busy", 32'(o_busy), 32'd1);
      chk("sw_e0_tt",   32'(o_tt),   32'd0);
      chk("sw_e0_ones", 32'(o_ones), 32'd0);
      for (int k = 1; k <= last; k++) begin
         start = (k == 5);
         tick();
         if (k < last) begin
            chk("sw_vars", 32'(o_vars), 32'(k / (settle + 1)));
            chk("sw_busy", 32'(o_busy), 32'd1);
            chk("sw_done_early", 32'(o_done), 32'd0);
         end else begin
            chk("sw_done",  32'(o_done), 32'd1);
            chk("sw_busy_d", 32'(o_busy), 32'd0);
            chk("sw_tt",    32'(o_tt),   32'(f));
            chk("sw_ones",  32'(o_ones), 32'($countones(f)));
            chk("sw_mm",    32'(o_mm),   32'(exp_mismatch(f)));
         end
      end
      // start presented during DONE must be dropped
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_done_pulse", 32'(o_done), 32'd0);
      chk("post_busy",       32'(o_busy), 32'd0);
      tick();
      chk("post_busy2", 32'(o_busy), 32'd0);
      chk("post_vars",  32'(o_vars), 32'd0);
      chk("hold_tt",    32'(o_tt),   32'(f));
      chk("hold_ones",  32'(o_ones), 32'($countones(f)));
      chk("hold_mm",    32'(o_mm),   32'(exp_mismatch(f)));
   endtask

   initial begin
      logic [7:0] f;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      sel   = 0;
      fn    = 8'h00;
      tick();
      tick();
      check_all_zero("rst_a");
      sel = 1;
      check_all_zero("rst_b");
      reset = 1'b0;
      tick();

      // fxy itself: s = ~x & ~y & z
      full_sweep(0, 1, 8'h02);
      // s tied high, long settle
      full_sweep(1, 3, 8'hFF);
      for (int r = 0; r < 3; r++) begin
         f = 8'($urandom);
         full_sweep(0, 1, f);
         f = 8'($urandom);
         full_sweep(1, 3, f);
      end

      // abort during SAMPLE of pattern 4: partial table, no write of tt[4]
      sel   = 0;
      f     = 8'($urandom) | 8'h10;
      fn    = f;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("ab_vars_pre", 32'(o_vars), 32'd4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", 32'(o_busy), 32'd0);
      chk("ab_vars", 32'(o_vars), 32'd0);
      chk("ab_done", 32'(o_done), 32'd0);
      chk("ab_tt",   32'(o_tt),   32'({4'b0000, f[3:0]}));
      chk("ab_ones", 32'(o_ones), 32'($countones(f[3:0])));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("ab_no_done", 32'(o_done), 32'd0);
      end
      chk("ab_tt_hold", 32'(o_tt), 32'({4'b0000, f[3:0]}));

      // start and abort together in IDLE: start wins; then abort in SETTLE
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 32'(o_busy), 32'd1);
      chk("sa_tt_clr", 32'(o_tt), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("sa_abort_busy", 32'(o_busy), 32'd0);
      chk("sa_abort_done", 32'(o_done), 32'd0);

      // asynchronous reset while vars=6
      f  = 8'($urandom);
      fn = f;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) tick();
      chk("rs_vars_pre", 32'(o_vars), 32'd6);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("rs_mid");
      #2;
      reset = 1'b0;
      tick();
      full_sweep(0, 1, 8'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
